writeback_sequencer: RTL
========================

// Module: writeback_sequencer
// PURPOSE
//  Writeback stage directly upstream of the register file: drives its 2-bit reg_write code and data_write bus.
//  Accepts one completed result per cycle (ALU result, load, link/call) over valid/ready.
//  Sequences loads through a single-outstanding data-memory read, then lane-selects and sign/zero-extends the word.
// PARAMETERS
//  DATA_W        32  datapath / register width
//  LOAD_TIMEOUT  16  max LD_WAIT cycles before abort (used only with WB_LOAD_TIMEOUT_EN)
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       synchronous reset, active-low (rst==0 resets on posedge clk)
//  in_valid      in   1       upstream result valid
//  in_ready      out  1       stage can accept; transfer when in_valid && in_ready
//  in_kind       in   2       00 ALU, 01 LOAD, 10 LINK, 11 NOWRITE
//  in_dst        in   1       0 -> write reg1-index register, 1 -> reg2-index register
//  in_data       in   DATA_W  ALU result / load byte address / PC for LINK
//  in_ld_size    in   2       00 byte, 01 half, 10 word, 11 treated as word
//  in_ld_signed  in   1       1 sign-extend, 0 zero-extend (loads only)
//  mem_req       out  1       one-cycle read request pulse
//  mem_addr      out  DATA_W  word-aligned read address {addr[31:2],2'b00}
//  mem_rvalid    in   1       read data valid
//  mem_rdata     in   DATA_W  read data, little-endian lanes
//  reg_write     out  2       00 none, 10 reg1-index, 11 reg2-index, 01 r31 (link)
//  data_write    out  DATA_W  write data, qualified by reg_write != 00
//  busy          out  1       state != IDLE
//  ld_err        out  1       one-cycle load-timeout pulse (tied 0 without macro)
// BEHAVIOUR
//  Reset: state IDLE; reg_write=00, data_write=0, mem_req=0, mem_addr=0, ld_err=0, busy=0; in_ready=1 after release.
//  States IDLE, LD_WAIT, WRITE. in_ready = (state != LD_WAIT). All outputs registered.
//  Accept (IDLE or WRITE): ALU -> WRITE, code in_dst?11:10, value in_data.
//    LINK -> WRITE, code 01, value in_data+4 (mod 2^DATA_W, carry dropped).
//    NOWRITE -> consumed, next state IDLE, no write.
//    LOAD -> latch addr/size/signed/dst, -> LD_WAIT; mem_req=1 and mem_addr valid in first LD_WAIT cycle only.
//  No accept in WRITE -> IDLE. Each WRITE lasts exactly one cycle; back-to-back ALU/LINK give one write per cycle.
//  LD_WAIT: mem_rvalid sampled every LD_WAIT cycle incl. the mem_req cycle (zero-wait memory legal);
//    on rvalid -> WRITE with extended value, code per latched dst. mem_rvalid outside LD_WAIT ignored.
//  Extraction: byte lane addr[1:0] (lane k = rdata[8k+7:8k]); half uses addr[1] (addr[0] ignored); word ignores addr[1:0].
//  Extension from bit 7/15 when signed, zero-fill otherwise; word unchanged.
//  Load latency: accept at t, mem_req at t+1, rvalid at t+k (k>=1), reg_write valid at t+k+1.
//  Reset mid-op: any state -> IDLE, pending load/write dropped, no write issued; late rvalid ignored.
//  reg_write never 00-with-pending-data ambiguity: data_write holds last value when reg_write=00.
// CONFIGURATION
//  WB_LOAD_TIMEOUT_EN defined: counter of width $clog2(LOAD_TIMEOUT+1) runs in LD_WAIT; after LOAD_TIMEOUT
//    cycles with no rvalid -> IDLE, no write, ld_err=1 for one cycle; rvalid on the final cycle wins over timeout.
//  Undefined: LD_WAIT waits indefinitely; ld_err tied 0; no counter logic.
// STRUCTURE
//  Package wb_pkg: kind codes (KIND_ALU/LOAD/LINK/NOWRITE), reg_write codes (RW_NONE/RW_LINK/RW_REG1/RW_REG2),
//    size codes (SZ_BYTE/HALF/WORD), state enum encoding.
//  Sub-module load_extender: combinational lane select + sign/zero extension (addr[1:0], size, signed, rdata -> value).
// TESTING
//  1 rst=0 for 3 cycles with in_valid=1 -> reg_write=00, data_write=0, mem_req=0, busy=0; in_ready=1 after release.
//  2 ALU dst0 0x00001234 then ALU dst1 0x0000DEAD on consecutive cycles -> 10/0x1234 then 11/0xDEAD, consecutive.
//  3 LINK in_data=0x00000040 -> next cycle reg_write=01, data_write=0x00000044; 0xFFFFFFFC -> 0x00000000.
//  4 LOAD byte signed addr 0x103, rdata 0x80FF1122 after 3 cycles -> mem_addr=0x100, in_ready=0 while waiting,
//    data_write=0xFFFFFF80; half unsigned addr 0x102 same rdata -> 0x000080FF.
//  5 rst=0 during LD_WAIT, then rvalid -> no write, state IDLE; NOWRITE accepted -> reg_write stays 00.
//  6 WB_LOAD_TIMEOUT_EN, LOAD_TIMEOUT=4, no rvalid -> ld_err pulse after 4 LD_WAIT cycles, no write, IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared kind, register-write, load-size and state encodings for the writeback stage
package wb_pkg;
  typedef enum logic [1:0] {KIND_ALU = 2'b00, KIND_LOAD = 2'b01, KIND_LINK = 2'b10, KIND_NOWRITE = 2'b11} kind_t;
  typedef enum logic [1:0] {RW_NONE = 2'b00, RW_LINK = 2'b01, RW_REG1 = 2'b10, RW_REG2 = 2'b11} rw_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_LD_WAIT = 2'b01, ST_WRITE = 2'b10} state_t;
endpackage

// File: rtl/load_extender.sv
// load_extender: little-endian lane select plus sign/zero extension of a loaded word
module load_extender
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        addr,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] value
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = rdata[{addr[1], 4'b0000} +: 16];
    value = size == SZ_BYTE ? {{(DATA_W-8){sgn & b[7]}}, b} :
            size == SZ_HALF ? {{(DATA_W-16){sgn & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/writeback_sequencer.sv
// writeback_sequencer: registered writeback stage with single-outstanding load sequencing
// Optional WB_LOAD_TIMEOUT_EN aborts a load after LOAD_TIMEOUT LD_WAIT cycles with an ld_err pulse.
module writeback_sequencer
  import wb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic              in_dst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        reg_write,
  output logic [DATA_W-1:0] data_write,
  output logic              busy,
  output logic              ld_err
);
  state_t            state, state_n;
  logic [1:0]        rw_n, l_lo, l_lo_n, l_size, l_size_n;
  logic              l_sgn, l_sgn_n, l_dst, l_dst_n, req_n, err_n, timeout;
  logic [DATA_W-1:0] data_n, addr_n, ext;
  load_extender #(.DATA_W(DATA_W)) u_ext (
    .addr(l_lo), .size(l_size), .sgn(l_sgn), .rdata(mem_rdata), .value(ext)
  );
`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst || state != ST_LD_WAIT) ? '0 : cnt + 1'b1;
  assign timeout = cnt == CW'(LOAD_TIMEOUT - 1);
`else
  assign timeout = 1'b0;
`endif
  assign in_ready = state != ST_LD_WAIT;
  assign busy     = state != ST_IDLE;
  always_comb begin
    state_n  = ST_IDLE;
    rw_n     = RW_NONE;
    data_n   = data_write;
    addr_n   = mem_addr;
    req_n    = 1'b0;
    err_n    = 1'b0;
    l_lo_n   = l_lo;
    l_size_n = l_size;
    l_sgn_n  = l_sgn;
    l_dst_n  = l_dst;
    if (state == ST_LD_WAIT) begin
      state_n = mem_rvalid ? ST_WRITE : timeout ? ST_IDLE : ST_LD_WAIT;
      rw_n    = mem_rvalid ? (l_dst ? RW_REG2 : RW_REG1) : RW_NONE;
      data_n  = mem_rvalid ? ext : data_write;
      err_n   = !mem_rvalid && timeout;
    end else if (in_valid) begin
      if (in_kind == KIND_LOAD) begin
        state_n  = ST_LD_WAIT;
        req_n    = 1'b1;
        addr_n   = {in_data[DATA_W-1:2], 2'b00};
        l_lo_n   = in_data[1:0];
        l_size_n = in_ld_size;
        l_sgn_n  = in_ld_signed;
        l_dst_n  = in_dst;
      end else if (in_kind != KIND_NOWRITE) begin
        state_n = ST_WRITE;
        rw_n    = in_kind == KIND_LINK ? RW_LINK : (in_dst ? RW_REG2 : RW_REG1);
        data_n  = in_kind == KIND_LINK ? in_data + DATA_W'(4) : in_data;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      reg_write  <= RW_NONE;
      data_write <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      ld_err     <= 1'b0;
      l_lo       <= '0;
      l_size     <= '0;
      l_sgn      <= 1'b0;
      l_dst      <= 1'b0;
    end else begin
      state      <= state_n;
      reg_write  <= rw_n;
      data_write <= data_n;
      mem_req    <= req_n;
      mem_addr   <= addr_n;
      ld_err     <= err_n;
      l_lo       <= l_lo_n;
      l_size     <= l_size_n;
      l_sgn      <= l_sgn_n;
      l_dst      <= l_dst_n;
    end
  end
endmodule
